// File: rtl/cache_line_reader.sv
// Read-side controller for the phased cache data array: waits on the tag result,
// reads one way for a single cycle, then streams bytes critical-byte-first with wrap.
module cache_line_reader #(
    parameter  int LINE_BYTES = 8,
    parameter  int WAYS       = 4,
    localparam int OFF_W      = $clog2(LINE_BYTES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [OFF_W-1:0]        req_offset,
    input  logic [OFF_W-1:0]        req_len,
    input  logic                    hit_valid,
    input  logic                    hit,
    input  logic [WAYS-1:0]         hit_way,
    output logic [WAYS-1:0]         way_rd_en,
    input  logic [LINE_BYTES*8-1:0] line_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_data,
    output logic                    out_last,
    output logic                    resp_miss,
    output logic                    busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_READ,
        S_STREAM
    } state_e;

    state_e                  state_q, state_d;
    logic [OFF_W-1:0]        ptr_q, ptr_d;
    logic [OFF_W-1:0]        rem_q, rem_d;
    logic [WAYS-1:0]         sel_way_q, sel_way_d;
    logic [LINE_BYTES*8-1:0] line_buf_q, line_buf_d;
    logic                    resp_miss_q, resp_miss_d;
    logic [WAYS-1:0]         lowest_hit;

    // Isolate the lowest set bit so a multi-hot tag result still enables one way.
    assign lowest_hit = hit_way & (~hit_way + WAYS'(1));

    // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        sel_way_d   = sel_way_q;
        line_buf_d  = line_buf_q;
        resp_miss_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    ptr_d   = req_offset;
                    rem_d   = req_len;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit_valid) begin
                    if (hit && (hit_way != '0)) begin
                        sel_way_d = lowest_hit;
                        state_d   = S_READ;
                    end else begin
                        resp_miss_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_READ: begin
                line_buf_d = line_data;
                state_d    = S_STREAM;
            end
            S_STREAM: begin
                if (out_ready) begin
                    ptr_d = ptr_q + OFF_W'(1);
                    if (rem_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        rem_d = rem_q - OFF_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            sel_way_q   <= '0;
            resp_miss_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            sel_way_q   <= sel_way_d;
            resp_miss_q <= resp_miss_d;
        end
    end

    // NOTE: the line buffer is data storage and is not reset; out_data is forced to 0 outside STREAM, so its contents never leak.
    always_ff @(posedge clk) begin
        line_buf_q <= line_buf_d;
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign way_rd_en = (state_q == S_READ) ? sel_way_q : '0;
    assign out_valid = (state_q == S_STREAM);
    assign out_last  = (state_q == S_STREAM) && (rem_q == '0);
    assign out_data  = (state_q == S_STREAM) ? line_buf_q[{ptr_q, 3'b000} +: 8] : 8'h00;
    assign resp_miss = resp_miss_q;

endmodule

// File: tb/tb_cache_line_reader.sv
// Randomized bench for cache_line_reader: a per-way byte array model predicts the
// wrapped byte sequence of every burst, plus directed miss, stall and reset-abort cases.
module tb_cache_line_reader;

    localparam int LINE_BYTES = 8;
    localparam int WAYS       = 4;
    localparam int OFF_W      = $clog2(LINE_BYTES);

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    req_valid;
    logic                    req_ready;
    logic [OFF_W-1:0]        req_offset;
    logic [OFF_W-1:0]        req_len;
    logic                    hit_valid;
    logic                    hit;
    logic [WAYS-1:0]         hit_way;
    logic [WAYS-1:0]         way_rd_en;
    logic [LINE_BYTES*8-1:0] line_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [7:0]              out_data;
    logic                    out_last;
    logic                    resp_miss;
    logic                    busy;

    logic [7:0]              mem [WAYS][LINE_BYTES];
    logic [LINE_BYTES*8-1:0] junk;
    int                      n_checks = 0;
    int                      n_errors = 0;

    cache_line_reader #(.LINE_BYTES(LINE_BYTES), .WAYS(WAYS)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_offset (req_offset),
        .req_len    (req_len),
        .hit_valid  (hit_valid),
        .hit        (hit),
        .hit_way    (hit_way),
        .way_rd_en  (way_rd_en),
        .line_data  (line_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .resp_miss  (resp_miss),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Data array model: the enabled way drives its line, otherwise the bus carries junk.
    always_comb begin
        line_data = junk;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_rd_en[w]) begin
                for (int b = 0; b < LINE_BYTES; b++) line_data[8*b +: 8] = mem[w][b];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int b = 0; b < LINE_BYTES; b++) junk[8*b +: 8] = 8'($urandom);
    endtask

    function automatic int lowest_way(input logic [WAYS-1:0] hw);
        for (int w = 0; w < WAYS; w++) if (hw[w]) return w;
        return -1;
    endfunction

    task automatic fill_mem();
        for (int w = 0; w < WAYS; w++)
            for (int b = 0; b < LINE_BYTES; b++) mem[w][b] = 8'($urandom);
        for (int b = 0; b < LINE_BYTES; b++) mem[2][b] = 8'(8'h10 + b);
    endtask

    // One full transaction. rmode: 0 ready always, 1 ready pattern 1,0,0, 2 random.
    // abort_at >= 0 asserts reset once that many bytes have been handshaken.
    task automatic run_req(input int off, input int len, input logic h, input logic [WAYS-1:0] hw,
                           input int hit_delay, input int rmode, input int abort_at);
        int   way;
        int   i;
        int   cyc;
        logic rdy;

        check("idle_ready", req_ready, 1);
        check("idle_busy", busy, 0);
        req_valid  = 1'b1;
        req_offset = OFF_W'(off);
        req_len    = OFF_W'(len);
        step();
        req_valid  = 1'b0;
        req_offset = OFF_W'($urandom);
        req_len    = OFF_W'($urandom);
        check("lookup_ready", req_ready, 0);
        check("lookup_busy", busy, 1);

        repeat (hit_delay) begin
            hit_valid = 1'b0;
            hit       = 1'($urandom);
            hit_way   = WAYS'($urandom);
            step();
            check("lookup_wait_en", way_rd_en, 0);
            check("lookup_wait_valid", out_valid, 0);
        end
        hit_valid = 1'b1;
        hit       = h;
        hit_way   = hw;
        step();
        hit_valid = 1'b0;
        hit       = 1'($urandom);
        hit_way   = WAYS'($urandom);

        way = h ? lowest_way(hw) : -1;
        if (way < 0) begin
            check("miss_pulse", resp_miss, 1);
            check("miss_en", way_rd_en, 0);
            check("miss_valid", out_valid, 0);
            check("miss_ready", req_ready, 1);
            step();
            check("miss_pulse_end", resp_miss, 0);
            check("miss_valid_after", out_valid, 0);
            return;
        end

        check("read_en", way_rd_en, 64'(1) << way);
        check("read_valid", out_valid, 0);
        check("read_miss", resp_miss, 0);
        step();
        check("stream_en_off", way_rd_en, 0);

        i   = 0;
        cyc = 0;
        while (i <= len && cyc < 200) begin
            if (abort_at >= 0 && i == abort_at) begin
                reset = 1'b1;
                step();
                check("abort_valid", out_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_ready", req_ready, 1);
                check("abort_last", out_last, 0);
                reset = 1'b0;
                return;
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            check("stream_valid", out_valid, 1);
            check("stream_data", out_data, mem[way][(off + i) % LINE_BYTES]);
            check("stream_last", out_last, (i == len));
            step();
            cyc++;
            if (rdy) i++;
        end
        out_ready = 1'b0;
        check("burst_handshakes", i, len + 1);
        check("done_valid", out_valid, 0);
        check("done_last", out_last, 0);
        check("done_ready", req_ready, 1);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_offset = '0;
        req_len    = '0;
        hit_valid  = 1'b0;
        hit        = 1'b0;
        hit_way    = '0;
        out_ready  = 1'b0;
        junk       = '0;
        fill_mem();
        repeat (3) step();
        check("rst_req_ready", req_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_way_rd_en", way_rd_en, 0);
        check("rst_resp_miss", resp_miss, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        step();
        check("idle_after_rst", req_ready, 1);

        run_req(6, 3, 1'b1, 4'b0100, 0, 0, -1);
        run_req(0, 7, 1'b1, 4'b0100, 0, 1, -1);
        run_req(3, 2, 1'b0, 4'b0100, 0, 0, -1);
        run_req(1, 4, 1'b1, 4'b0110, 1, 0, -1);
        run_req(5, 0, 1'b1, 4'b0000, 0, 0, -1);
        run_req(0, 7, 1'b1, 4'b0100, 0, 0, 2);
        run_req(4, 7, 1'b1, 4'b1000, 2, 2, -1);
        run_req(7, 7, 1'b1, 4'b0001, 0, 0, -1);

        repeat (300) begin
            int off;
            int len;
            fill_mem();
            off = $urandom_range(0, LINE_BYTES - 1);
            len = $urandom_range(0, LINE_BYTES - 1);
            run_req(off, len, 1'($urandom_range(0, 3) != 0), WAYS'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 2),
                    ($urandom_range(0, 19) == 0) ? $urandom_range(0, len) : -1);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cache_line_reader.md
Name: cache_line_reader

Overview:
Read-side controller for the phased cache data array. It accepts a byte-read request, waits for the tag phase to report hit/miss, and then enables exactly one way of the flop-based data array for one cycle. It captures the selected line and streams the requested bytes in critical-byte-first, wrap-around order over a valid/ready interface. It sits between the tag compare logic and the requester, and is the read counterpart of the data byte storage write path.

Parameters:
LINE_BYTES, 8, bytes per cache line; power of two, 2..64
WAYS, 4, number of ways; sets the width of hit_way and way_rd_en
OFF_W, $clog2(LINE_BYTES), byte offset / length field width (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  read request present
req_ready  output  1  controller can accept a request
req_offset  input  OFF_W  first byte of line to return
req_len  input  OFF_W  number of bytes minus 1 (0 = 1 byte, LINE_BYTES-1 = full line)
hit_valid  input  1  tag-phase result valid this cycle
hit  input  1  tag-phase result is a hit
hit_way  input  WAYS  one-hot hitting way
way_rd_en  output  WAYS  one-hot data-array way read enable
line_data  input  LINE_BYTES*8  selected way's line; byte i at bits [8i+7:8i]
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts byte
out_data  output  8  returned byte
out_last  output  1  final byte of the burst
resp_miss  output  1  one-cycle pulse: request missed, no data follows
busy  output  1  state != IDLE

Behaviour:
- Reset (synchronous): state=IDLE. All registered outputs are 0: out_valid, out_last, out_data, way_rd_en, resp_miss, busy. req_ready is 1 in IDLE. Offset, count and way registers are cleared. Reset has priority over all other inputs in every state, including mid-stream.
- States: IDLE, LOOKUP, READ, STREAM.
- IDLE: req_ready=1.
  - req_valid&&req_ready: latch req_offset to ptr and req_len to remaining.
  - -> LOOKUP.
- LOOKUP: req_ready=0. hit_valid is ignored in every other state.
  - hit_valid=0: stay.
  - hit_valid&&hit&&hit_way!=0: latch the lowest set bit of hit_way as sel_way (a non-one-hot value is reduced to its lowest bit). -> READ.
  - hit_valid&&(!hit || hit_way==0): resp_miss=1 for the next cycle only. -> IDLE.
- READ (exactly one cycle):
  - way_rd_en=sel_way; otherwise way_rd_en is 0 in all states.
  - line_data is combinational from the array and is captured into line_buf at the end of this cycle.
  - -> STREAM.
- STREAM:
  - out_valid=1, out_data=line_buf[ptr], out_last=(remaining==0).
  - On out_valid&&out_ready: ptr <= ptr+1 mod LINE_BYTES (natural OFF_W wrap) and remaining <= remaining-1.
  - If out_last was set on that handshake: out_valid=0, out_last=0 next cycle. -> IDLE.
  - out_ready=0: out_data and out_last stay stable, and no state changes.
- Latency:
  - Accept at cycle 0 gives LOOKUP at cycle 1.
  - hit_valid sampled at edge k gives READ at cycle k+1 and first out_valid at cycle k+2.
  - The minimum request-to-first-byte time is 3 cycles, with hit_valid in cycle 1.
- Throughput: 1 byte/cycle with out_ready held high. A new request is accepted the cycle after the last handshake (IDLE).
- Arithmetic: remaining and ptr are OFF_W bits and must never underflow; exit is on remaining==0. req_len=LINE_BYTES-1 from any offset returns every byte exactly once.
- line_buf is held unchanged outside READ. Changes on line_data during STREAM must not affect the output.

Test Plan:
(LINE_BYTES=8, WAYS=4; the way-2 line holds bytes 0x10..0x17 at byte 0..7.)
- Reset, then idle -> req_ready=1; out_valid, way_rd_en, resp_miss, busy all 0.
- Request offset=6, len=3; hit_valid=1, hit=1, hit_way=4'b0100 in cycle 1; out_ready=1 -> way_rd_en=4'b0100 for exactly one cycle. Output is 0x16, 0x17, 0x10, 0x11 on consecutive cycles, with out_last only on 0x11. req_ready returns next cycle.
- Request offset=0, len=7, hit; out_ready toggles 1,0,0,1,... -> all 8 bytes 0x10..0x17 in order. Stall cycles repeat the same out_data. Exactly 8 handshakes occur.
- Request offset=3, hit_valid=1 with hit=0 -> resp_miss high for exactly one cycle, way_rd_en stays 0, out_valid never asserts, back to IDLE.
- hit_way=4'b0110 with hit=1 -> way_rd_en=4'b0010. hit=1 with hit_way=0 -> treated as miss (resp_miss pulse).
- Assert reset mid-STREAM after 2 bytes of a len=7 burst -> next cycle out_valid=0, busy=0, req_ready=1. A fresh request then completes normally, with no residue from the aborted burst.
